// File: rtl/f32_delta_stage.sv
`default_nettype none
// ============================================================================
// Module      : f32_delta_stage
// Description : Pairs each binary32 sample with its predecessor for an x - y
//               subtractor, via a 2-entry registered output FIFO.
// Revision    : 1.0
// ============================================================================
module f32_delta_stage #(
    parameter int FIRST_MODE = 0,
    parameter int COUNT_W    = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clear,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [31:0]        in_data,
    input  logic               in_last,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [31:0]        out_x,
    output logic [31:0]        out_y,
    output logic               out_first,
    output logic               out_last,
    output logic [COUNT_W-1:0] frame_pairs,
    output logic [COUNT_W-1:0] nan_count
);

    localparam int c_ENTRY_W = 66;

    typedef enum logic [0:0] {
        S_EMPTY  = 1'b0,
        S_PRIMED = 1'b1
    } state_t;

    state_t               state_q, state_d;
    logic [31:0]          prev_q, prev_d;
    logic [c_ENTRY_W-1:0] head_q, head_d;
    logic [c_ENTRY_W-1:0] tail_q, tail_d;
    logic [1:0]           cnt_q, cnt_d;
    logic [COUNT_W-1:0]   fcnt_q, fcnt_d;
    logic [COUNT_W-1:0]   fpairs_q, fpairs_d;
    logic [COUNT_W-1:0]   nan_q, nan_d;

    logic                 w_accept;
    logic                 w_pop;
    logic                 w_push;
    logic                 w_is_nan;
    logic [c_ENTRY_W-1:0] w_new_entry;
    logic [COUNT_W-1:0]   w_fcnt_inc;

    // Reset gates in_ready so it reads 0 while rst_n is held low.
    assign in_ready  = rst_n & ~clear & (cnt_q != 2'd2);
    assign out_valid = (cnt_q != 2'd0);
    assign w_accept  = in_valid & in_ready;
    assign w_pop     = out_valid & out_ready;
    assign w_is_nan  = (&in_data[30:23]) & (|in_data[22:0]);

    assign out_x       = head_q[65:34];
    assign out_y       = head_q[33:2];
    assign out_first   = head_q[1];
    assign out_last    = head_q[0];
    assign frame_pairs = fpairs_q;
    assign nan_count   = nan_q;

    always_comb begin
        state_d     = state_q;
        prev_d      = prev_q;
        w_push      = 1'b0;
        w_new_entry = {in_data, prev_q, 1'b0, in_last};
        if (w_accept) begin
            prev_d  = in_data;
            state_d = in_last ? S_EMPTY : S_PRIMED;
            if (state_q == S_PRIMED) begin
                w_push = 1'b1;
            end else if (FIRST_MODE == 1) begin
                w_push      = 1'b1;
                w_new_entry = {in_data, 32'h0000_0000, 1'b1, in_last};
            end
        end

        head_d = head_q;
        tail_d = tail_q;
        cnt_d  = cnt_q;
        case (cnt_q)
            2'd0: begin
                if (w_push) begin
                    head_d = w_new_entry;
                    cnt_d  = 2'd1;
                end
            end
            2'd1: begin
                if (w_push && w_pop) begin
                    head_d = w_new_entry;
                end else if (w_push) begin
                    tail_d = w_new_entry;
                    cnt_d  = 2'd2;
                end else if (w_pop) begin
                    cnt_d  = 2'd0;
                end
            end
            default: begin
                if (w_pop) begin
                    head_d = tail_q;
                    cnt_d  = 2'd1;
                end
            end
        endcase

        w_fcnt_inc = fcnt_q + {{(COUNT_W-1){1'b0}}, w_push};
        fcnt_d     = fcnt_q;
        fpairs_d   = fpairs_q;
        nan_d      = nan_q;
        if (w_accept) begin
            if (in_last) begin
                fpairs_d = w_fcnt_inc;
                fcnt_d   = '0;
            end else begin
                fcnt_d   = w_fcnt_inc;
            end
            if (w_is_nan && !(&nan_q)) begin
                nan_d = nan_q + 1'b1;
            end
        end

        // Flush wins over any accept or pop in the same cycle.
        if (clear) begin
            state_d  = S_EMPTY;
            prev_d   = '0;
            head_d   = '0;
            tail_d   = '0;
            cnt_d    = 2'd0;
            fcnt_d   = '0;
            fpairs_d = '0;
            nan_d    = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_EMPTY;
            prev_q   <= '0;
            head_q   <= '0;
            tail_q   <= '0;
            cnt_q    <= 2'd0;
            fcnt_q   <= '0;
            fpairs_q <= '0;
            nan_q    <= '0;
        end else begin
            state_q  <= state_d;
            prev_q   <= prev_d;
            head_q   <= head_d;
            tail_q   <= tail_d;
            cnt_q    <= cnt_d;
            fcnt_q   <= fcnt_d;
            fpairs_q <= fpairs_d;
            nan_q    <= nan_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_f32_delta_stage.sv
`default_nettype none
// Bench for f32_delta_stage: a drop-first instance and a first-pair instance
// (narrow counters) share one stimulus stream, each checked against a model.
module tb_f32_delta_stage;

    logic clk, rst_n, clear, in_valid, in_last, out_ready;
    logic [31:0] in_data;
    logic [1:0] ir, ov, ofst, olst;
    logic [1:0][31:0] ox, oy;
    logic [15:0] fp0, nc0;
    logic [3:0]  fp1, nc1;

    int checks = 0;
    int failures = 0;

    f32_delta_stage #(.FIRST_MODE(0), .COUNT_W(16)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid),
        .in_ready(ir[0]), .in_data(in_data), .in_last(in_last),
        .out_valid(ov[0]), .out_ready(out_ready), .out_x(ox[0]), .out_y(oy[0]),
        .out_first(ofst[0]), .out_last(olst[0]), .frame_pairs(fp0), .nan_count(nc0));

    f32_delta_stage #(.FIRST_MODE(1), .COUNT_W(4)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid),
        .in_ready(ir[1]), .in_data(in_data), .in_last(in_last),
        .out_valid(ov[1]), .out_ready(out_ready), .out_x(ox[1]), .out_y(oy[1]),
        .out_first(ofst[1]), .out_last(olst[1]), .frame_pairs(fp1), .nan_count(nc1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: logical FIFO contents and counters per instance.
    logic [65:0] mq[2][2];
    int          mcnt[2];
    logic [31:0] mprev[2];
    bit          mprimed[2];
    int          mfcnt[2], mfp[2], mnan[2];
    int          mmode[2];
    int          mmask[2];
    logic [65:0] log0[$];
    logic [65:0] log1[$];

    task automatic chk(input string nm, input logic [65:0] act, input logic [65:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    task automatic model_reset(input int i);
        mcnt[i] = 0; mprev[i] = 32'h0; mprimed[i] = 0;
        mfcnt[i] = 0; mfp[i] = 0; mnan[i] = 0;
    endtask

    task automatic model_step(input int i);
        bit acc, pop, push;
        logic [65:0] e;
        if (clear) begin
            model_reset(i);
            return;
        end
        acc = in_valid && (mcnt[i] < 2);
        pop = (mcnt[i] > 0) && out_ready;
        if (pop) begin
            mq[i][0] = mq[i][1];
            mcnt[i]--;
        end
        if (acc) begin
            push = 0;
            if (mprimed[i]) begin
                push = 1; e = {in_data, mprev[i], 1'b0, in_last};
            end else if (mmode[i] == 1) begin
                push = 1; e = {in_data, 32'h0, 1'b1, in_last};
            end
            if (push) begin
                mq[i][mcnt[i]] = e;
                mcnt[i]++;
            end
            mfcnt[i] = (mfcnt[i] + (push ? 1 : 0)) & mmask[i];
            if (in_last) begin
                mfp[i] = mfcnt[i];
                mfcnt[i] = 0;
            end
            mprev[i] = in_data;
            mprimed[i] = !in_last;
            if (in_data[30:23] == 8'hFF && in_data[22:0] != 0 && mnan[i] < mmask[i])
                mnan[i]++;
        end
    endtask

    task automatic compare(input int i);
        logic [65:0] head;
        logic [65:0] fpa, nca;
        head = {ox[i], oy[i], ofst[i], olst[i]};
        fpa  = (i == 0) ? 66'(fp0) : 66'(fp1);
        nca  = (i == 0) ? 66'(nc0) : 66'(nc1);
        chk($sformatf("d%0d_in_ready", i), 66'(ir[i]), 66'((mcnt[i] < 2) && !clear && rst_n));
        chk($sformatf("d%0d_out_valid", i), 66'(ov[i]), 66'(mcnt[i] != 0));
        if (mcnt[i] != 0) begin
            chk($sformatf("d%0d_head", i), head, mq[i][0]);
            if (out_ready) begin
                if (i == 0) log0.push_back(head); else log1.push_back(head);
            end
        end
        chk($sformatf("d%0d_frame_pairs", i), fpa, 66'(mfp[i]));
        chk($sformatf("d%0d_nan_count", i), nca, 66'(mnan[i]));
    endtask

    task automatic cycle();
        @(negedge clk);
        if (!rst_n) begin
            model_reset(0);
            model_reset(1);
        end
        compare(0);
        compare(1);
        if (rst_n) begin
            model_step(0);
            model_step(1);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] d, input logic l);
        in_valid = 1'b1; in_data = d; in_last = l;
        cycle();
        in_valid = 1'b0; in_last = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cycle();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1);
    end

    initial begin
        logic [65:0] tmp;
        logic [31:0] pool[8];
        mmode[0] = 0; mmode[1] = 1;
        mmask[0] = 65535; mmask[1] = 15;
        model_reset(0); model_reset(1);
        rst_n = 1'b1; clear = 1'b0; in_valid = 1'b0; in_last = 1'b0;
        in_data = 32'h0; out_ready = 1'b1;
        #1 rst_n = 1'b0;
        idle(2);
        chk("reset_out_x", 66'(ox[0]), 66'h0);
        chk("reset_out_y", 66'(oy[1]), 66'h0);
        chk("reset_in_ready", 66'(ir), 66'h0);
        rst_n = 1'b1;
        idle(1);

        // Reference frame 1.0, 2.0, 3.0.
        log0.delete(); log1.delete();
        send(32'h3F800000, 0); send(32'h40000000, 0); send(32'h40400000, 1);
        idle(3);
        chk("f_d0_count", 66'(log0.size()), 66'd2);
        chk("f_d1_count", 66'(log1.size()), 66'd3);
        if (log0.size() == 2) begin
            chk("f_d0_p0", log0[0], {32'h40000000, 32'h3F800000, 2'b00});
            chk("f_d0_p1", log0[1], {32'h40400000, 32'h40000000, 2'b01});
        end
        if (log1.size() == 3) begin
            chk("f_d1_p0", log1[0], {32'h3F800000, 32'h00000000, 2'b10});
            chk("f_d1_p1", log1[1], {32'h40000000, 32'h3F800000, 2'b00});
            chk("f_d1_p2", log1[2], {32'h40400000, 32'h40000000, 2'b01});
        end
        chk("f_d0_frame_pairs", 66'(fp0), 66'd2);
        chk("f_d1_frame_pairs", 66'(fp1), 66'd3);

        // Backpressure: four samples into a stalled output.
        log0.delete(); log1.delete();
        out_ready = 1'b0;
        send(32'h41000000, 0); send(32'h41100000, 0);
        send(32'h41200000, 0);
        chk("bp_d0_in_ready", 66'(ir[0]), 66'd0);
        send(32'h41300000, 0);
        out_ready = 1'b1;
        idle(3);
        chk("bp_d0_count", 66'(log0.size()), 66'd2);
        if (log0.size() == 2) begin
            chk("bp_d0_p0", log0[0], {32'h41100000, 32'h41000000, 2'b00});
            chk("bp_d0_p1", log0[1], {32'h41200000, 32'h41100000, 2'b00});
        end
        chk("bp_d1_count", 66'(log1.size()), 66'd2);

        // NaN counting and bit-exact forwarding.
        clear = 1'b1; idle(1); clear = 1'b0;
        log0.delete(); log1.delete();
        send(32'h7FC00000, 0); send(32'h7F800000, 0); send(32'hFF800001, 1);
        idle(3);
        chk("nan_d0_count", 66'(nc0), 66'd2);
        chk("nan_d0_pairs", 66'(log0.size()), 66'd2);
        if (log0.size() == 2) begin
            tmp = log0[0];
            chk("nan_d0_y_bits", 66'(tmp[33:2]), 66'h7FC00000);
            tmp = log0[1];
            chk("nan_d0_x_bits", 66'(tmp[65:34]), 66'hFF800001);
        end

        // Clear with one pair buffered and a sample offered.
        out_ready = 1'b0;
        send(32'h3F800000, 0); send(32'h40000000, 0);
        clear = 1'b1; in_valid = 1'b1; in_data = 32'h40400000;
        cycle();
        clear = 1'b0; in_valid = 1'b0;
        chk("clr_out_valid", 66'(ov), 66'd0);
        chk("clr_frame_pairs", 66'(fp0), 66'd0);
        chk("clr_nan_count", 66'(nc0), 66'd0);
        out_ready = 1'b1;
        log0.delete(); log1.delete();
        send(32'h40800000, 0); send(32'h40A00000, 1);
        idle(2);
        chk("clr_d0_after", 66'(log0.size()), 66'd1);
        if (log0.size() == 1)
            chk("clr_d0_pair", log0[0], {32'h40A00000, 32'h40800000, 2'b01});

        // Asynchronous reset mid-frame.
        send(32'h3F800000, 0); send(32'h40000000, 0);
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid", 66'(ov), 66'd0);
        chk("arst_out_x", 66'(ox[0]), 66'h0);
        chk("arst_out_y", 66'(oy[0]), 66'h0);
        idle(1);
        rst_n = 1'b1;
        log0.delete(); log1.delete();
        send(32'h40400000, 0);
        idle(2);
        chk("arst_no_pair", 66'(log0.size()), 66'd0);

        // Randomized traffic.
        pool[0] = 32'h3F800000; pool[1] = 32'h7FC00000; pool[2] = 32'h7F800000;
        pool[3] = 32'hFF800001; pool[4] = 32'h00000001; pool[5] = 32'h80000000;
        for (int n = 0; n < 3000; n++) begin
            pool[6] = $urandom; pool[7] = $urandom;
            in_valid  = ($urandom % 4) != 0;
            in_data   = pool[$urandom % 8];
            in_last   = ($urandom % 4) == 0;
            out_ready = ($urandom % 10) < 7;
            clear     = ($urandom % 256) == 0;
            rst_n     = ($urandom % 300) != 0;
            cycle();
        end
        rst_n = 1'b1; clear = 1'b0; in_valid = 1'b0;
        idle(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/f32_delta_stage.md
F32_DELTA_STAGE -- requirements
Module: f32_delta_stage

Interface
REQ-001 SHALL have parameter FIRST_MODE, default 0: 0 = drop first sample of a frame; 1 = emit pair (sample, +0.0).
REQ-002 SHALL have parameter COUNT_W, default 16: width of the statistics counters.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 clear  input  1  synchronous flush of state, buffer and counters.
REQ-006 in_valid  input  1  upstream sample valid.
REQ-007 in_ready  output  1  block accepts sample this cycle.
REQ-008 in_data  input  32  IEEE-754 binary32 sample.
REQ-009 in_last  input  1  sample is last of its frame.
REQ-010 out_valid  output  1  operand pair valid, feeding the f32 subtractor as x - y.
REQ-011 out_ready  input  1  downstream consumes pair this cycle.
REQ-012 out_x  output  32  minuend (current sample).
REQ-013 out_y  output  32  subtrahend (previous sample, or 32'h0000_0000).
REQ-014 out_first  output  1  pair carries first sample of frame (FIRST_MODE=1 only).
REQ-015 out_last  output  1  pair carries last sample of frame.
REQ-016 frame_pairs  output  COUNT_W  pairs emitted in most recently completed frame.
REQ-017 nan_count  output  COUNT_W  saturating count of accepted NaN samples.

Function
REQ-018 Accept = in_valid & in_ready; in_ready SHALL be 1 iff output buffer holds <2 entries and clear=0.
REQ-019 State machine SHALL have states EMPTY (no previous sample) and PRIMED (prev register valid).
REQ-020 EMPTY + accept: prev <= in_data; if FIRST_MODE=1 enqueue {in_data, 32'h0, first=1, last=in_last}; next state PRIMED, or EMPTY if in_last.
REQ-021 PRIMED + accept: enqueue {in_data, prev, first=0, last=in_last}; prev <= in_data; next state EMPTY if in_last, else PRIMED.
REQ-022 FIRST_MODE=0, single-sample frame (in_last accepted in EMPTY): nothing enqueued; frame_pairs <= 0.
REQ-023 Samples SHALL pass bit-exact; no arithmetic or canonicalisation; NaN/Inf/denormal forwarded unchanged.
REQ-024 Output buffer SHALL be a 2-entry FIFO; out_valid = non-empty; out_* driven from head entry, registered.
REQ-025 Latency: pair enqueued at cycle N SHALL be visible with out_valid=1 at cycle N+1 when FIFO was empty.
REQ-026 While out_valid=1 and out_ready=0, out_x/out_y/out_first/out_last SHALL hold stable.
REQ-027 Simultaneous push and pop at occupancy 1 SHALL leave occupancy 1 with new entry at head next cycle; order strictly FIFO.
REQ-028 Full (2 entries): in_ready=0; a pop frees one slot for the following cycle (no same-cycle bypass of in_ready).
REQ-029 An internal frame counter SHALL count pairs enqueued in the current frame; on accept with in_last, frame_pairs <= count including that beat, counter <= 0.
REQ-030 nan_count SHALL increment on each accepted sample with exponent 8'hFF and fraction != 0; SHALL saturate at all-ones.
REQ-031 clear=1 SHALL, next edge: state EMPTY, FIFO empty, prev <= 0, frame counter, frame_pairs, nan_count <= 0; clear has priority over any accept and pop that cycle.

Reset
REQ-032 rst_n=0 SHALL immediately force: state EMPTY, FIFO empty, out_valid=0, out_x=out_y=0, out_first=out_last=0, frame_pairs=0, nan_count=0, prev=0.
REQ-033 in_ready SHALL be 0 during reset and 1 on first cycle after release.
REQ-034 Reset mid-frame SHALL discard prev and buffered pairs; next accepted sample treated as frame start.

Verification
REQ-035 FIRST_MODE=0, out_ready=1, frame 1.0 (3F800000), 2.0 (40000000), 3.0 (40400000, last) -> pairs (40000000,3F800000), (40400000,40000000,last=1); frame_pairs=2.
REQ-036 FIRST_MODE=1, same frame -> pairs (3F800000,00000000,first=1), (40000000,3F800000), (40400000,40000000,last=1); frame_pairs=3.
REQ-037 out_ready=0, stream 4 samples -> two pairs buffered, in_ready=0 after third accept; release out_ready -> pairs delivered in order, none lost or duplicated.
REQ-038 Inputs 7FC00000, 7F800000, FF800001 -> nan_count=2; pairs forward 7FC00000 and FF800001 bit-exact.
REQ-039 Assert clear with FIFO holding 1 pair and in_valid=1 -> next cycle out_valid=0, sample not accepted, counters 0, state EMPTY.
REQ-040 Drive rst_n low mid-frame after 2 samples -> outputs zero asynchronously; after release, sample 40400000 produces no pair (FIRST_MODE=0).
